// File: rtl/instr_encoder.sv
// RV32I field-set to machine-word encoder with a 2-entry output FIFO and address counter.
// Define ENCODER_RANGE_CHECK_EN to reject immediates that do not fit their encoding field.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  srcreg1_num,
  input  logic [4:0]  srcreg2_num,
  input  logic [4:0]  dstreg_num,
  input  logic [31:0] imm,
  input  logic [5:0]  alucode,
  input  logic [1:0]  aluop1_type,
  input  logic [1:0]  aluop2_type,
  input  logic        is_load,
  input  logic        is_store,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  // ALU_* / OP_TYPE_* codes shared with the decoder
  localparam logic [5:0] ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2;
  localparam logic [5:0] ALU_BEQ  = 6'd3,  ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5;
  localparam logic [5:0] ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7,  ALU_BGEU = 6'd8;
  localparam logic [5:0] ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11;
  localparam logic [5:0] ALU_LBU  = 6'd12, ALU_LHU  = 6'd13;
  localparam logic [5:0] ALU_SB   = 6'd14, ALU_SH   = 6'd15, ALU_SW   = 6'd16;
  localparam logic [5:0] ALU_ADD  = 6'd17, ALU_SUB  = 6'd18, ALU_XOR  = 6'd19;
  localparam logic [5:0] ALU_OR   = 6'd20, ALU_AND  = 6'd21, ALU_SLT  = 6'd22;
  localparam logic [5:0] ALU_SLTU = 6'd23, ALU_SLL  = 6'd24, ALU_SRL  = 6'd25;
  localparam logic [5:0] ALU_SRA  = 6'd26;
  localparam logic [1:0] OP_TYPE_NONE = 2'd0, OP_TYPE_REG = 2'd1;
  localparam logic [1:0] OP_TYPE_IMM  = 2'd2, OP_TYPE_PC  = 2'd3;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011, OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BRNCH = 7'b1100011, OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111, OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111, OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } entry_t;

  fmt_e        fmt;
  logic [6:0]  opc, f7;
  logic [2:0]  f3, alu_f3;
  logic        alu_ok, is_shift, cls_bad, range_bad, illegal;
  logic [31:0] word;
  logic signed [31:0] simm;

  entry_t      fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        acc, push, pop;

  // Opcode class selection: first matching rule wins.
  always_comb begin
    fmt     = FMT_R;
    opc     = OPC_OP;
    f3      = 3'b000;
    f7      = 7'b0;
    cls_bad = 1'b0;
    alu_ok  = 1'b1;
    alu_f3  = 3'b000;
    case (alucode)
      ALU_ADD, ALU_SUB: alu_f3 = 3'b000;
      ALU_SLL:          alu_f3 = 3'b001;
      ALU_SLT:          alu_f3 = 3'b010;
      ALU_SLTU:         alu_f3 = 3'b011;
      ALU_XOR:          alu_f3 = 3'b100;
      ALU_SRL, ALU_SRA: alu_f3 = 3'b101;
      ALU_OR:           alu_f3 = 3'b110;
      ALU_AND:          alu_f3 = 3'b111;
      default:          alu_ok = 1'b0;
    endcase
    is_shift = alucode inside {ALU_SLL, ALU_SRL, ALU_SRA};

    if (is_load) begin
      opc = OPC_LOAD;
      fmt = FMT_I;
      case (alucode)
        ALU_LB:  f3 = 3'b000;
        ALU_LH:  f3 = 3'b001;
        ALU_LW:  f3 = 3'b010;
        ALU_LBU: f3 = 3'b100;
        ALU_LHU: f3 = 3'b101;
        default: cls_bad = 1'b1;
      endcase
    end else if (is_store) begin
      opc = OPC_STORE;
      fmt = FMT_S;
      case (alucode)
        ALU_SB:  f3 = 3'b000;
        ALU_SH:  f3 = 3'b001;
        ALU_SW:  f3 = 3'b010;
        default: cls_bad = 1'b1;
      endcase
    end else if (alucode inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU}) begin
      opc = OPC_BRNCH;
      fmt = FMT_B;
      case (alucode)
        ALU_BNE:  f3 = 3'b001;
        ALU_BLT:  f3 = 3'b100;
        ALU_BGE:  f3 = 3'b101;
        ALU_BLTU: f3 = 3'b110;
        ALU_BGEU: f3 = 3'b111;
        default:  f3 = 3'b000;
      endcase
    end else if (alucode == ALU_LUI) begin
      opc = OPC_LUI;
      fmt = FMT_U;
    end else if (alucode == ALU_JAL) begin
      opc = OPC_JAL;
      fmt = FMT_J;
    end else if (alucode == ALU_JALR) begin
      opc = OPC_JALR;
      fmt = FMT_I;
    end else if (alucode == ALU_ADD && aluop1_type == OP_TYPE_PC) begin
      opc = OPC_AUIPC;
      fmt = FMT_U;
    end else if (aluop2_type == OP_TYPE_IMM) begin
      opc     = OPC_OPIMM;
      fmt     = is_shift ? FMT_SH : FMT_I;
      f3      = alu_f3;
      f7      = (alucode == ALU_SRA) ? F7_ALT : 7'b0;
      cls_bad = !alu_ok || (alucode == ALU_SUB);
    end else if (aluop2_type == OP_TYPE_REG) begin
      opc     = OPC_OP;
      fmt     = FMT_R;
      f3      = alu_f3;
      f7      = (alucode == ALU_SUB || alucode == ALU_SRA) ? F7_ALT : 7'b0;
      cls_bad = !alu_ok;
    end else begin
      cls_bad = 1'b1;
    end
  end

  // Field packing and immediate range check per instruction format.
  always_comb begin
    simm      = imm;
    word      = 32'h0;
    range_bad = 1'b0;
    case (fmt)
      FMT_R: word = {f7, srcreg2_num, srcreg1_num, f3, dstreg_num, opc};
      FMT_I: begin
        word      = {imm[11:0], srcreg1_num, f3, dstreg_num, opc};
        range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_SH: begin
        word      = {f7, imm[4:0], srcreg1_num, f3, dstreg_num, opc};
        range_bad = (imm > 32'd31);
      end
      FMT_S: begin
        word      = {imm[11:5], srcreg2_num, srcreg1_num, f3, imm[4:0], opc};
        range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_B: begin
        word      = {imm[12], imm[10:5], srcreg2_num, srcreg1_num, f3, imm[4:1], imm[11], opc};
        range_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
      end
      FMT_U: begin
        word      = {imm[31:12], dstreg_num, opc};
        range_bad = (imm[11:0] != 12'h0);
      end
      FMT_J: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], dstreg_num, opc};
        range_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
      end
      default: word = 32'h0;
    endcase
    illegal = cls_bad | (RANGE_EN & range_bad);
  end

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_q[rd_ptr_q].data : 32'h0;
  assign out_addr  = out_valid ? fifo_q[rd_ptr_q].addr : addr_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

  // Illegal sets complete the handshake but never reach the FIFO.
  assign acc  = in_valid && in_ready;
  assign push = acc && !illegal;
  assign pop  = out_valid && out_ready;

  always_comb begin
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    addr_d    = push ? addr_q + 32'd4 : addr_q;
    err_d     = err_q | (acc && illegal);
    err_cnt_d = (acc && illegal && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{data: word, addr: addr_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
